// File: rtl/ula_operand_loader.sv
// ula_operand_loader: byte-serial opcode/A/B loader driving the ULA logic blocks; optional idle timeout under ULA_LOADER_TIMEOUT_EN.
module ula_operand_loader #(
  parameter int DATA_W = 8,
  parameter int NUM_OPS = 5
`ifdef ULA_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic [NUM_OPS-1:0] op_sel,
  input  logic [15:0]       ula_result,
  input  logic              ula_zero,
  output logic [15:0]       res_data,
  output logic              res_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              err_illegal,
`ifdef ULA_LOADER_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic [15:0]       op_count
);
  localparam int OPW = $clog2(NUM_OPS);
  typedef enum logic [2:0] {S_OP, S_A, S_B, S_EXEC, S_RESULT} state_t;
  state_t state, next;
  logic [OPW-1:0] opcode;
  logic xfer, legal, tmo, loading;
  assign loading = state == S_A || state == S_B;
  assign in_ready = !rst && (state == S_OP || loading);
  assign xfer = in_valid && in_ready;
  assign legal = in_data < DATA_W'(NUM_OPS);
  assign res_valid = state == S_RESULT;
  assign op_sel = state == S_EXEC ? NUM_OPS'(1) << opcode : '0;
`ifdef ULA_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = loading && !xfer && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo;
      tcnt <= (!loading || xfer || next != state) ? '0 : tcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      S_OP:     next = xfer && legal ? S_A : S_OP;
      S_A:      next = xfer ? S_B : tmo ? S_OP : S_A;
      S_B:      next = xfer ? S_EXEC : tmo ? S_OP : S_B;
      S_EXEC:   next = S_RESULT;
      S_RESULT: next = res_ready ? S_OP : S_RESULT;
      default:  next = S_OP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode <= '0;
      ula_a <= '0;
      ula_b <= '0;
      res_data <= '0;
      res_zero <= 1'b0;
      err_illegal <= 1'b0;
      op_count <= '0;
    end else begin
      err_illegal <= state == S_OP && xfer && !legal;
      if (state == S_OP && xfer && legal) opcode <= in_data[OPW-1:0];
      if (state == S_A && xfer) ula_a <= in_data;
      if (state == S_B && xfer) ula_b <= in_data;
      if (state == S_EXEC) begin
        res_data <= ula_result;
        res_zero <= ula_zero;
      end
      if (state == S_RESULT && res_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_ula_operand_loader.sv
// tb_ula_operand_loader: table-driven and randomized checks of the operand loader against a transaction-level model.
module tb_ula_operand_loader;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, ula_zero, res_zero, res_valid, res_ready = 0, err_illegal;
  logic [7:0] in_data = 0, ula_a, ula_b;
  logic [4:0] op_sel;
  logic [15:0] ula_result, res_data, op_count, exp_cnt = 0;
  int checks = 0, errors = 0, sel_pulses = 0, ill_pulses = 0;
`ifdef ULA_LOADER_TIMEOUT_EN
  logic err_timeout;
`endif
  ula_operand_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ula_a(ula_a), .ula_b(ula_b), .op_sel(op_sel), .ula_result(ula_result), .ula_zero(ula_zero),
    .res_data(res_data), .res_zero(res_zero), .res_valid(res_valid), .res_ready(res_ready),
    .err_illegal(err_illegal),
`ifdef ULA_LOADER_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .op_count(op_count));

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return {8'h00, a & b};
      1: return {8'h00, a | b};
      2: return ~{8'h00, a & b};
      3: return {8'h00, a ^ b};
      default: return ~{8'h00, a | b};
    endcase
  endfunction

  // Logic-block stand-in: returns a marker value when no block is selected.
  always_comb begin
    ula_result = 16'hDEAD;
    ula_zero = 1'b0;
    for (int i = 0; i < 5; i++)
      if (op_sel[i]) begin
        ula_result = ref_op(i, ula_a, ula_b);
        ula_zero = ula_result == 16'h0000;
      end
  end

  always @(negedge clk) begin
    if (op_sel != 0) sel_pulses++;
    if (err_illegal) ill_pulses++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    in_data = d;
    in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte in_ready never rose at %0t", $time);
    end
    @(negedge clk);
    in_valid = 0;
    in_data = 8'($urandom);
  endtask

  task automatic do_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input int hold,
                        input int idle, input logic [15:0] er, input logic ez);
    int s0 = sel_pulses;
    send_byte(op);
    send_byte(a);
    repeat (idle) @(negedge clk);
    if (idle > 0) chk("idle_in_ready", in_ready, 1);
    send_byte(b);
    chk("exec_op_sel", op_sel, 32'(5'b1 << op));
    chk("exec_a", ula_a, a);
    chk("exec_b", ula_b, b);
    chk("exec_in_ready", in_ready, 0);
    chk("exec_res_valid", res_valid, 0);
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, er);
    chk("res_zero", res_zero, ez);
    chk("res_op_sel", op_sel, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, er);
      chk("hold_in_ready", in_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    exp_cnt++;
    #1;
    chk("post_res_valid", res_valid, 0);
    chk("post_op_count", op_count, exp_cnt);
    chk("post_in_ready", in_ready, 1);
    chk("op_sel_pulses", sel_pulses - s0, 1);
  endtask

  typedef struct {
    logic [7:0] op, a, b;
    int hold;
    logic [15:0] res;
    logic zero;
  } vec_t;
  vec_t vt[5];

  initial begin
    int s0, i0;
    vt[0] = '{8'h00, 8'hF0, 8'h3C, 0, 16'h0030, 1'b0};
    vt[1] = '{8'h03, 8'h5A, 8'h5A, 0, 16'h0000, 1'b1};
    vt[2] = '{8'h04, 8'h0F, 8'h30, 10, 16'hFFC0, 1'b0};
    vt[3] = '{8'h01, 8'h0F, 8'hF0, 0, 16'h00FF, 1'b0};
    vt[4] = '{8'h02, 8'hFF, 8'hFF, 2, 16'hFF00, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_op_sel", op_sel, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) do_txn(vt[i].op, vt[i].a, vt[i].b, vt[i].hold, 0, vt[i].res, vt[i].zero);
    s0 = sel_pulses;
    i0 = ill_pulses;
    send_byte(8'h07);
    chk("ill_pulse", err_illegal, 1);
    chk("ill_in_ready", in_ready, 1);
    @(negedge clk);
    chk("ill_pulse_end", err_illegal, 0);
    send_byte(8'h05);
    chk("ill_boundary", err_illegal, 1);
    @(negedge clk);
    #1;
    chk("ill_count", ill_pulses - i0, 2);
    chk("ill_no_sel", sel_pulses - s0, 0);
    do_txn(vt[3].op, vt[3].a, vt[3].b, 0, 0, vt[3].res, vt[3].zero);
    send_byte(8'h02);
    send_byte(8'h77);
    rst = 1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_op_count", op_count, 0);
    chk("arst_a", ula_a, 0);
    chk("arst_res", {res_data, res_zero, res_valid, err_illegal}, 0);
    @(negedge clk);
    rst = 0;
    exp_cnt = 0;
    @(negedge clk);
    do_txn(vt[0].op, vt[0].a, vt[0].b, 0, 0, vt[0].res, vt[0].zero);
    do_txn(vt[4].op, vt[4].a, vt[4].b, vt[4].hold, 0, vt[4].res, vt[4].zero);
`ifndef ULA_LOADER_TIMEOUT_EN
    do_txn(8'h01, 8'h12, 8'h34, 0, 20, ref_op(1, 8'h12, 8'h34), 1'b0);
`endif
    for (int n = 0; n < 25; n++) begin
      logic [7:0] op, a, b;
      logic [15:0] r;
      if ($urandom_range(0, 4) == 0) begin
        send_byte(8'($urandom_range(5, 255)));
        chk("rnd_illegal", err_illegal, 1);
      end
      op = 8'($urandom_range(0, 4));
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      r = ref_op(int'(op), a, b);
      do_txn(op, a, b, $urandom_range(0, 3), 0, r, r == 16'h0000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
